// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: shared widths, defaults and MEM/WB bundle for the memory-access stage
package mem_stage_pkg;
  localparam int DATA_W = 8;
  localparam int REG_ADDR_W = 5;
  localparam int PC_SIZE_DEF = 10;
  localparam int DMEM_DEPTH_DEF = 256;
  typedef struct packed {
    logic [DATA_W-1:0] read_data;
    logic [DATA_W-1:0] alu_result;
    logic mem_to_reg;
    logic reg_write;
    logic [REG_ADDR_W-1:0] write_register;
  } mem_wb_t;
endpackage

// File: rtl/mem_stage_data_memory.sv
// data_memory: DEPTH x 8 array, async read, sync write, zeroed at power-up only
module data_memory
  import mem_stage_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH_DEF
) (
  input  logic clock,
  input  logic we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
  assign rdata = mem[addr];
  always_ff @(posedge clock)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: data-memory access, branch resolution to fetch, and the MEM/WB register
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_SIZE = PC_SIZE_DEF,
  parameter int DMEM_DEPTH = DMEM_DEPTH_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic [PC_SIZE-1:0] PC_jump_in,
  input  logic zero_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [DATA_W-1:0] write_data_in,
  input  logic branch_in,
  input  logic mem_read_in,
  input  logic mem_write_in,
  input  logic mem_to_reg_in,
  input  logic reg_write_in,
  input  logic [REG_ADDR_W-1:0] write_register_in,
  output logic pc_src,
  output logic [PC_SIZE-1:0] PC_jump_out,
  output logic [DATA_W-1:0] read_data,
  output logic [DATA_W-1:0] ALU_result_out,
  output logic mem_to_reg_out,
  output logic reg_write_out,
  output logic [REG_ADDR_W-1:0] write_register_out
);
  localparam int AW = $clog2(DMEM_DEPTH);
  logic [DATA_W-1:0] mem_data;
  mem_wb_t mem_wb;
  // Async read gives the pre-store value, so a same-cycle load+store sees old data
  data_memory #(.DEPTH(DMEM_DEPTH)) dmem (
    .clock(clock),
    .we(mem_write_in & ~reset),
    .addr(ALU_result_in[AW-1:0]),
    .wdata(write_data_in),
    .rdata(mem_data)
  );
  assign pc_src = branch_in & zero_in & ~reset;
  assign PC_jump_out = PC_jump_in;
  always_ff @(posedge clock)
    mem_wb <= reset ? '0 : '{
      read_data: mem_read_in ? mem_data : '0,
      alu_result: ALU_result_in,
      mem_to_reg: mem_to_reg_in,
      reg_write: reg_write_in,
      write_register: write_register_in
    };
  assign read_data = mem_wb.read_data;
  assign ALU_result_out = mem_wb.alu_result;
  assign mem_to_reg_out = mem_wb.mem_to_reg;
  assign reg_write_out = mem_wb.reg_write;
  assign write_register_out = mem_wb.write_register;
endmodule
